// File: rtl/entry_pkg.sv
// ----------------------------------------------------------------------------
// entry_pkg
// Shared constants and types for the six-digit BCD entry block.
//   NUM_DIGITS   : number of seven-segment digits driven (HEX5..HEX0)
//   DIGIT_W      : bits per BCD digit
//   digit_t      : one BCD digit nibble
//   CURSOR_RESET : one-hot cursor after reset (HEX5 selected)
// ----------------------------------------------------------------------------
package entry_pkg;

    localparam int NUM_DIGITS = 6;
    localparam int DIGIT_W    = 4;

    typedef logic [DIGIT_W-1:0] digit_t;

    localparam logic [NUM_DIGITS-1:0] CURSOR_RESET = 6'b100000;

endpackage

// File: rtl/key_debounce.sv
// ----------------------------------------------------------------------------
// key_debounce
// Two-flop synchronizer, debounce counter and falling-edge press pulse for one
// raw active-low push-button.
// Ports:
//   clk   : system clock, rising edge
//   rst   : synchronous active-high reset
//   key   : raw asynchronous key level (0 = pressed)
//   press : one-cycle registered pulse on an accepted 1->0 transition
//   level : debounced stable key level
// ----------------------------------------------------------------------------
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic press,
    output logic level
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic [CNT_W-1:0] cnt;
    logic             stable;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
            stable  <= 1'b1;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            // synchronizer stage
            sync_p0 <= key;
            sync_p1 <= sync_p0;
            // debounce stage: the level must disagree for DEBOUNCE_CYCLES
            // consecutive cycles; any agreement restarts the count
            press <= 1'b0;
            if (sync_p1 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= sync_p1;
                cnt    <= '0;
                // only the release->pressed direction is a press
                press  <= ~sync_p1;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign level = stable;

endmodule

// File: rtl/bcd_digit_entry.sv
// ----------------------------------------------------------------------------
// bcd_digit_entry
// Button-driven entry of six BCD digits with a blinking cursor.
// KEY[0] advances the one-hot cursor HEX5 -> HEX0 (wrapping), KEY[1]
// increments the digit under the cursor (wrapping DIGIT_MAX -> 0).
// Ports:
//   MAX10_CLK1_50 : system clock, rising edge
//   RESET         : synchronous active-high reset
//   KEY[1:0]      : raw active-low buttons (0 = advance, 1 = increment)
//   DIGITS[23:0]  : six BCD digits, [23:20] = HEX5 ... [3:0] = HEX0
//   CURSOR[5:0]   : one-hot selected digit, bit 5 = HEX5
//   BLANK[5:0]    : CURSOR gated by the blink phase
//   PRESS[1:0]    : registered one-cycle pulses of accepted presses
// ----------------------------------------------------------------------------
module bcd_digit_entry
    import entry_pkg::*;
#(
    parameter int                            DEBOUNCE_CYCLES = 500000,
    parameter int                            BLINK_CYCLES    = 12500000,
    parameter int                            DIGIT_MAX       = 9,
    parameter logic [NUM_DIGITS*DIGIT_W-1:0] RESET_DIGITS    = 24'h000000
) (
    input  logic                            MAX10_CLK1_50,
    input  logic                            RESET,
    input  logic [1:0]                      KEY,
    output logic [NUM_DIGITS*DIGIT_W-1:0]   DIGITS,
    output logic [NUM_DIGITS-1:0]           CURSOR,
    output logic [NUM_DIGITS-1:0]           BLANK,
    output logic [1:0]                      PRESS
);

    localparam int            BW         = $clog2(BLINK_CYCLES + 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);
    localparam digit_t        DMAX       = digit_t'(DIGIT_MAX);

    // Wrap at DIGIT_MAX; an out-of-range nibble (bad reset value) also
    // wraps to 0 so digits return to the legal range on first edit.
    function automatic digit_t digit_inc(input digit_t d);
        return (d >= DMAX) ? '0 : d + digit_t'(1);
    endfunction

    logic [1:0] db_press;
    logic [1:0] level_unused;

    for (genvar k = 0; k < 2; k++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk   (MAX10_CLK1_50),
            .rst   (RESET),
            .key   (KEY[k]),
            .press (db_press[k]),
            .level (level_unused[k])
        );
    end

    logic [NUM_DIGITS*DIGIT_W-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]         cursor_q, cursor_d;
    logic [NUM_DIGITS-1:0]         blank_q, blank_d;
    logic [1:0]                    press_q;
    logic [BW-1:0]                 bcnt_q, bcnt_d;
    logic                          phase_q, phase_d;

    always_comb begin
        digits_d = digits_q;
        cursor_d = cursor_q;
        bcnt_d   = bcnt_q;
        phase_d  = phase_q;

        // increment acts on the cursor as it was before any advance this edge
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (press_q[1] && cursor_q[i]) begin
                digits_d[i*DIGIT_W +: DIGIT_W] = digit_inc(digits_q[i*DIGIT_W +: DIGIT_W]);
            end
        end

        if (press_q[0]) begin
            cursor_d = {cursor_q[0], cursor_q[NUM_DIGITS-1:1]};
        end

        // any press restarts the blink so the edited digit is visible at once
        if (|press_q) begin
            bcnt_d  = '0;
            phase_d = 1'b0;
        end else if (bcnt_q == BLINK_LAST) begin
            bcnt_d  = '0;
            phase_d = ~phase_q;
        end else begin
            bcnt_d = bcnt_q + BW'(1);
        end

        blank_d = phase_d ? cursor_d : '0;
    end

    always_ff @(posedge MAX10_CLK1_50) begin
        if (RESET) begin
            digits_q <= RESET_DIGITS;
            cursor_q <= CURSOR_RESET;
            blank_q  <= '0;
            press_q  <= '0;
            bcnt_q   <= '0;
            phase_q  <= 1'b0;
        end else begin
            // PRESS is held one cycle and consumed at the following edge
            digits_q <= digits_d;
            cursor_q <= cursor_d;
            blank_q  <= blank_d;
            press_q  <= db_press;
            bcnt_q   <= bcnt_d;
            phase_q  <= phase_d;
        end
    end

    assign DIGITS = digits_q;
    assign CURSOR = cursor_q;
    assign BLANK  = blank_q;
    assign PRESS  = press_q;

endmodule

// File: tb/tb_bcd_digit_entry.sv
module tb_bcd_digit_entry;

    localparam int          D    = 4;
    localparam int          B    = 8;
    localparam int          DMAX = 9;
    localparam logic [23:0] RD   = 24'h030200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  key = 2'b11;
    logic [23:0] digits;
    logic [5:0]  cursor;
    logic [5:0]  blank;
    logic [1:0]  press;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    bcd_digit_entry #(
        .DEBOUNCE_CYCLES(D),
        .BLINK_CYCLES   (B),
        .DIGIT_MAX      (DMAX),
        .RESET_DIGITS   (RD)
    ) dut (
        .MAX10_CLK1_50(clk),
        .RESET        (rst),
        .KEY          (key),
        .DIGITS       (digits),
        .CURSOR       (cursor),
        .BLANK        (blank),
        .PRESS        (press)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: digits as integers, cursor as a position index,
    // blink phase derived from cycles elapsed since the last clear.
    // ------------------------------------------------------------------
    bit         m_valid = 0;
    int         m_dig[6];
    int         m_pos;          // 5 = HEX5 ... 0 = HEX0
    bit  [1:0]  m_ff1, m_sync;  // raw key seen one / two edges ago
    bit  [1:0]  m_stable;
    int         m_run[2];       // consecutive cycles sync level disagrees
    bit  [1:0]  m_acc;          // press accepted at the last edge
    bit  [1:0]  m_press;        // PRESS visible this cycle
    int         m_since;        // cycles since reset or last press

    function automatic logic [23:0] m_digits();
        logic [23:0] v;
        for (int i = 0; i < 6; i++) v[i*4 +: 4] = 4'(m_dig[i]);
        return v;
    endfunction

    function automatic logic [5:0] m_cursor();
        return 6'(1 << m_pos);
    endfunction

    function automatic logic [5:0] m_blank();
        return (((m_since / B) % 2) == 1) ? m_cursor() : 6'd0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1;
            for (int i = 0; i < 6; i++) m_dig[i] = int'(RD[i*4 +: 4]);
            m_pos    = 5;
            m_ff1    = 2'b11;
            m_sync   = 2'b11;
            m_stable = 2'b11;
            m_run[0] = 0;
            m_run[1] = 0;
            m_acc    = 2'b00;
            m_press  = 2'b00;
            m_since  = 0;
        end else begin
            if (m_press[1]) m_dig[m_pos] = (m_dig[m_pos] >= DMAX) ? 0 : m_dig[m_pos] + 1;
            if (m_press[0]) m_pos = (m_pos == 0) ? 5 : m_pos - 1;
            if (m_press != 2'b00) m_since = 0;
            else m_since++;
            m_press = m_acc;
            m_acc   = 2'b00;
            for (int b = 0; b < 2; b++) begin
                if (m_sync[b] != m_stable[b]) begin
                    m_run[b]++;
                    if (m_run[b] == D) begin
                        m_stable[b] = m_sync[b];
                        m_run[b]    = 0;
                        m_acc[b]    = ~m_sync[b];
                    end
                end else begin
                    m_run[b] = 0;
                end
            end
            m_sync = m_ff1;
            m_ff1  = key;
        end
    end

    // Compare every cycle once the model is defined
    always @(negedge clk) begin
        if (m_valid) begin
            chk("digits", digits, m_digits());
            chk("cursor", cursor, m_cursor());
            chk("blank",  blank,  m_blank());
            chk("press",  press,  m_press);
        end
    end

    int p1_q[$];
    always @(negedge clk) if (m_valid && press[1] === 1'b1) p1_q.push_back(cyc);

    initial begin
        #500000;
        $display("FAIL watchdog cycle=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog");
    end

    task automatic do_press(input logic [1:0] mask);
        @(negedge clk);
        key = key & ~mask;
        repeat (6) @(negedge clk);
        key = key | mask;
        repeat (8) @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int          t;
        int          base;
        int          c0;
        bit          found;
        logic [5:0]  walk[6];
        logic [5:0]  blink_sel;

        walk = '{6'b010000, 6'b001000, 6'b000100, 6'b000010, 6'b000001, 6'b100000};

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_digits", digits, 24'h030200);
        chk("rst_cursor", cursor, 6'b100000);
        chk("rst_blank",  blank,  6'b000000);
        chk("rst_press",  press,  2'b00);
        chk("model_rst_digits", m_digits(), 24'h030200);
        rst = 1'b0;

        // single increment press: held 10 cycles, exactly one pulse at t+6
        @(negedge clk);
        key[1] = 1'b0;
        t = cyc + 1;
        base = p1_q.size();
        repeat (10) @(negedge clk);
        key[1] = 1'b1;
        repeat (10) @(negedge clk);
        chk("t1_press_count", p1_q.size() - base, 1);
        if (p1_q.size() > base) chk("t1_press_cycle", p1_q[base], t + 6);
        chk("t1_digits", digits, 24'h130200);
        chk("model_t1_digits", m_digits(), 24'h130200);

        // bounce shorter than the debounce interval
        base = p1_q.size();
        @(negedge clk);
        key[1] = 1'b0;
        repeat (3) @(negedge clk);
        key[1] = 1'b1;
        repeat (10) @(negedge clk);
        chk("bounce_press_count", p1_q.size() - base, 0);
        chk("bounce_digits", digits, 24'h130200);

        // ten increments of HEX5 starting from 0
        pulse_reset();
        for (int k = 1; k <= 10; k++) begin
            do_press(2'b10);
            chk("inc_hex5", digits[23:20], 32'(k % 10));
        end

        // cursor walk
        for (int k = 0; k < 6; k++) begin
            do_press(2'b01);
            chk("walk_cursor", cursor, walk[k]);
        end

        // set up HEX0 = 9 with cursor on HEX0
        repeat (5) do_press(2'b01);
        repeat (9) do_press(2'b10);
        chk("pre_both_cursor", cursor, 6'b000001);
        chk("pre_both_hex0", digits[3:0], 4'd9);

        // simultaneous presses
        @(negedge clk);
        key = 2'b00;
        found = 0;
        for (int i = 0; i < 12 && !found; i++) begin
            @(negedge clk);
            if (press === 2'b11) found = 1;
        end
        chk("both_pulse_seen", found, 1);
        chk("both_hold_hex0", digits[3:0], 4'd9);
        @(negedge clk);
        chk("both_hex0", digits[3:0], 4'd0);
        chk("both_cursor", cursor, 6'b100000);
        key = 2'b11;
        repeat (10) @(negedge clk);

        // blink with cursor on HEX3
        do_press(2'b01);
        do_press(2'b01);
        blink_sel = 6'b001000;
        chk("blink_cursor", cursor, blink_sel);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (blank !== 6'b000000) found = 1;
        end
        chk("blink_start_seen", found, 1);
        c0 = cyc;
        for (int i = 0; i < 32; i++) begin
            chk("blink_pattern", blank, (((i / 8) % 2) == 0) ? blink_sel : 6'b000000);
            if (i < 31) @(negedge clk);
        end
        // press lands late in a lit phase; the clear must blank at once
        key[1] = 1'b0;
        found = 0;
        for (int i = 0; i < 12 && !found; i++) begin
            @(negedge clk);
            if (press[1] === 1'b1) found = 1;
        end
        chk("clear_pulse_seen", found, 1);
        chk("clear_pulse_cycle", cyc, c0 + 38);
        chk("clear_before", blank, blink_sel);
        @(negedge clk);
        chk("clear_after", blank, 6'b000000);
        key[1] = 1'b1;
        repeat (10) @(negedge clk);

        // reset in the middle of a debounce window, key held through it
        @(negedge clk);
        key[1] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_digits", digits, 24'h030200);
        chk("mid_rst_cursor", cursor, 6'b100000);
        chk("mid_rst_blank",  blank,  6'b000000);
        chk("mid_rst_press",  press,  2'b00);
        rst = 1'b0;
        t = cyc + 1;
        base = p1_q.size();
        repeat (12) @(negedge clk);
        chk("mid_rst_count", p1_q.size() - base, 1);
        if (p1_q.size() > base) chk("mid_rst_cycle", p1_q[base], t + 6);
        key[1] = 1'b1;
        repeat (10) @(negedge clk);
        chk("mid_rst_after", digits, 24'h130200);

        // randomized key activity with occasional resets
        for (int n = 0; n < 300; n++) begin
            key = 2'($urandom);
            repeat ($urandom_range(1, 9)) @(negedge clk);
            if ($urandom_range(0, 40) == 0) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end
        key = 2'b11;
        repeat (20) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
